vtc_prog: RTL and testbench

Parametrised, runtime-reconfigurable video timing controller; successor to the fixed 640x480 timing generator. Produces registered hsync/vsync/active, frame and line markers and pixel coordinates for any mode whose totals fit in `CW` bits. It sits between the pixel-clock domain and the pixel pipeline / TMDS encoder and drives their timing.

---
 rtl/vtc_prog.sv | 150 +++++++++++++++
 tb/tb_vtc_prog.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vtc_prog.sv
// vtc_prog: programmable video timing generator; all outputs registered 1 cycle after counter state, all state holds while i_en=0.
// VTC_PROG_RUNTIME_CFG_EN: when defined, the shadow timing set reloads from the i_h_*/i_v_* ports at every frame end.
module vtc_prog #(
  parameter int CW       = 12,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic [CW-1:0] i_h_active,
  input  logic [CW-1:0] i_h_fp,
  input  logic [CW-1:0] i_h_sync,
  input  logic [CW-1:0] i_h_bp,
  input  logic [CW-1:0] i_v_active,
  input  logic [CW-1:0] i_v_fp,
  input  logic [CW-1:0] i_v_sync,
  input  logic [CW-1:0] i_v_bp,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_active,
  output logic          o_sof,
  output logic          o_eol,
  output logic [CW-1:0] o_counterX,
  output logic [CW-1:0] o_counterY,
  output logic [15:0]   o_frame_cnt
);

  typedef struct packed {
    logic [CW-1:0] ha, hf, hs, hb;
    logic [CW-1:0] va, vf, vs, vb;
  } timing_t;

  localparam timing_t P_DEF = {CW'(H_ACTIVE), CW'(H_FP), CW'(H_SYNC), CW'(H_BP),
                               CW'(V_ACTIVE), CW'(V_FP), CW'(V_SYNC), CW'(V_BP)};
  localparam logic    HS_ON = (HS_POL != 0);
  localparam logic    VS_ON = (VS_POL != 0);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW:0]   ONE_W = (CW+1)'(1);

  timing_t       shadow;
  logic [CW-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [15:0]   frame_q, frame_d;
  logic [CW:0]   htot, vtot, hs_beg, hs_end, vs_beg, vs_end, cx_w, cy_w;
  logic          x_last, y_last, frame_end;
  logic          hs_asserted, vs_asserted, active, sof, eol;

`ifdef VTC_PROG_RUNTIME_CFG_EN
  timing_t shadow_q;
  timing_t cfg_in;

  assign cfg_in = {i_h_active, i_h_fp, i_h_sync, i_h_bp,
                   i_v_active, i_v_fp, i_v_sync, i_v_bp};
  assign shadow = shadow_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          shadow_q <= P_DEF;
    else if (frame_end) shadow_q <= cfg_in;
  end
`else
  logic unused_cfg;

  assign shadow     = P_DEF;
  assign unused_cfg = ^{i_h_active, i_h_fp, i_h_sync, i_h_bp,
                        i_v_active, i_v_fp, i_v_sync, i_v_bp};
`endif

  // Totals and sync edges carried at CW+1 bits so the sums themselves never wrap.
  assign hs_beg = (CW+1)'(shadow.ha) + (CW+1)'(shadow.hf);
  assign hs_end = hs_beg + (CW+1)'(shadow.hs);
  assign htot   = hs_end + (CW+1)'(shadow.hb);
  assign vs_beg = (CW+1)'(shadow.va) + (CW+1)'(shadow.vf);
  assign vs_end = vs_beg + (CW+1)'(shadow.vs);
  assign vtot   = vs_end + (CW+1)'(shadow.vb);

  assign cx_w      = {1'b0, cx_q};
  assign cy_w      = {1'b0, cy_q};
  assign x_last    = (cx_w == htot - ONE_W);
  assign y_last    = (cy_w == vtot - ONE_W);
  assign frame_end = i_en && x_last && y_last;

  assign hs_asserted = (cx_w >= hs_beg) && (cx_w < hs_end);
  assign vs_asserted = (cy_w >= vs_beg) && (cy_w < vs_end);
  assign active      = (cx_q < shadow.ha) && (cy_q < shadow.va);
  assign sof         = (cx_q == '0) && (cy_q == '0);
  assign eol         = (cx_q == shadow.ha - ONE) && (cy_q < shadow.va);

  always_comb begin
    cx_d    = cx_q;
    cy_d    = cy_q;
    frame_d = frame_q;
    if (i_en) begin
      if (x_last) begin
        cx_d = '0;
        if (y_last) begin
          cy_d    = '0;
          frame_d = frame_q + 16'd1;
        end else begin
          cy_d = cy_q + ONE;
        end
      end else begin
        cx_d = cx_q + ONE;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cx_q    <= '0;
      cy_q    <= '0;
      frame_q <= '0;
    end else begin
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      frame_q <= frame_d;
    end
  end

  assign o_frame_cnt = frame_q;

  // Output stage samples the pre-advance counter, giving one cycle of latency.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_hsync    <= ~HS_ON;
      o_vsync    <= ~VS_ON;
      o_active   <= 1'b0;
      o_sof      <= 1'b0;
      o_eol      <= 1'b0;
      o_counterX <= '0;
      o_counterY <= '0;
    end else if (i_en) begin
      o_hsync    <= hs_asserted ? HS_ON : ~HS_ON;
      o_vsync    <= vs_asserted ? VS_ON : ~VS_ON;
      o_active   <= active;
      o_sof      <= sof;
      o_eol      <= eol;
      o_counterX <= cx_q;
      o_counterY <= cy_q;
    end
  end

endmodule

// File: tb/tb_vtc_prog.sv
// Bench for vtc_prog: a reduced-size mode keeps frames short; a second instance checks inverted sync polarity.
// Each enabled step pushes the model's expected outputs to a queue, popped and compared after the edge.
module tb_vtc_prog;
  localparam int CW = 12;
  localparam int HA = 16, HF = 2, HS = 3, HB = 4;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic          hs, vs, act, sof, eol;
    logic [CW-1:0] x, y;
    logic [15:0]   fc;
  } obs_t;

  logic clk = 1'b0;
  logic rst, en;
  logic [CW-1:0] h_a, h_f, h_s, h_b, v_a, v_f, v_s, v_b;
  logic p_hs, p_vs, p_act, p_sof, p_eol, n_hs, n_vs, n_act, n_sof, n_eol;
  logic [CW-1:0] p_x, p_y, n_x, n_y;
  logic [15:0] p_fc, n_fc;
  obs_t obs_p, obs_n;

  always #5 clk = ~clk;

  vtc_prog #(.CW(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
             .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .HS_POL(1), .VS_POL(1)) dut_p (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .i_h_active(h_a), .i_h_fp(h_f), .i_h_sync(h_s), .i_h_bp(h_b),
    .i_v_active(v_a), .i_v_fp(v_f), .i_v_sync(v_s), .i_v_bp(v_b),
    .o_hsync(p_hs), .o_vsync(p_vs), .o_active(p_act), .o_sof(p_sof), .o_eol(p_eol),
    .o_counterX(p_x), .o_counterY(p_y), .o_frame_cnt(p_fc));

  vtc_prog #(.CW(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
             .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .HS_POL(0), .VS_POL(0)) dut_n (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .i_h_active(h_a), .i_h_fp(h_f), .i_h_sync(h_s), .i_h_bp(h_b),
    .i_v_active(v_a), .i_v_fp(v_f), .i_v_sync(v_s), .i_v_bp(v_b),
    .o_hsync(n_hs), .o_vsync(n_vs), .o_active(n_act), .o_sof(n_sof), .o_eol(n_eol),
    .o_counterX(n_x), .o_counterY(n_y), .o_frame_cnt(n_fc));

  assign obs_p = {p_hs, p_vs, p_act, p_sof, p_eol, p_x, p_y, p_fc};
  assign obs_n = {n_hs, n_vs, n_act, n_sof, n_eol, n_x, n_y, n_fc};

  int   tests = 0, fails = 0;
  int   mx, my, mfc, cyc;
  int   sh[8];
  obs_t held;
  obs_t exp_q[$];
  int   act_cnt, eol_cnt, eol_bad, hs_bad, vs_bad, hs_cnt, sof_seen, sof_period, last_sof;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic obs_t model_out();
    obs_t o;
    int hb0 = sh[0] + sh[1];
    int vb0 = sh[4] + sh[5];
    o.hs  = (mx >= hb0) && (mx < hb0 + sh[2]);
    o.vs  = (my >= vb0) && (my < vb0 + sh[6]);
    o.act = (mx < sh[0]) && (my < sh[4]);
    o.sof = (mx == 0) && (my == 0);
    o.eol = (mx == sh[0] - 1) && (my < sh[4]);
    o.x   = CW'(mx);
    o.y   = CW'(my);
    o.fc  = 16'(mfc);
    return o;
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mfc = 0;
    sh = '{HA, HF, HS, HB, VA, VF, VS, VB};
    held = '0;
    held.hs = 1'b0;
    held.vs = 1'b0;
    exp_q.delete();
  endtask

  function automatic obs_t invert_sync(input obs_t o);
    obs_t r = o;
    r.hs = ~o.hs;
    r.vs = ~o.vs;
    return r;
  endfunction

  task automatic clear_stats();
    act_cnt = 0; eol_cnt = 0; eol_bad = 0; hs_bad = 0; vs_bad = 0; hs_cnt = 0;
    sof_seen = 0; sof_period = -1; last_sof = -1;
  endtask

  // One clock: drive en, advance the model, then pop and compare both instances.
  task automatic step(input logic e);
    obs_t ex;
    en = e;
    @(posedge clk);
    if (e) begin
      held = model_out();
      if (mx == sh[0] + sh[1] + sh[2] + sh[3] - 1) begin
        mx = 0;
        if (my == sh[4] + sh[5] + sh[6] + sh[7] - 1) begin
          my  = 0;
          mfc = (mfc + 1) % 65536;
`ifdef VTC_PROG_RUNTIME_CFG_EN
          sh = '{int'(h_a), int'(h_f), int'(h_s), int'(h_b), int'(v_a), int'(v_f), int'(v_s), int'(v_b)};
`endif
        end else begin
          my++;
        end
      end else begin
        mx++;
      end
      held.fc = 16'(mfc);
    end
    exp_q.push_back(held);
    #1;
    ex = exp_q.pop_front();
    chk("step_pos", 64'(obs_p), 64'(ex));
    chk("step_neg", 64'(obs_n), 64'(invert_sync(ex)));
    cyc++;
    if (e) begin
      if (obs_p.act) act_cnt++;
      if (obs_p.hs) hs_cnt++;
      if (obs_p.eol) begin
        eol_cnt++;
        if (obs_p.x != CW'(HA - 1) || obs_p.y >= CW'(VA)) eol_bad++;
      end
      if (obs_p.hs !== (obs_p.x >= CW'(HA + HF) && obs_p.x < CW'(HA + HF + HS))) hs_bad++;
      if (obs_p.vs !== (obs_p.y >= CW'(VA + VF) && obs_p.y < CW'(VA + VF + VS))) vs_bad++;
      if (obs_p.sof) begin
        if (last_sof >= 0) sof_period = cyc - last_sof;
        last_sof = cyc;
        sof_seen++;
      end
    end
  endtask

  task automatic run_to_sof(input string tag);
    int start = sof_seen;
    for (int i = 0; i < 4 * FT && sof_seen == start; i++) step(1'b1);
    chk({tag, "_sof_found"}, 64'(sof_seen - start), 64'd1);
  endtask

  task automatic set_cfg(input int a, f, s, b, va, vf, vs, vb);
    h_a = CW'(a); h_f = CW'(f); h_s = CW'(s); h_b = CW'(b);
    v_a = CW'(va); v_f = CW'(vf); v_s = CW'(vs); v_b = CW'(vb);
  endtask

  obs_t rst_exp;

  initial begin
    rst_exp = '0;
    cyc = 0;
    set_cfg(HA, HF, HS, HB, VA, VF, VS, VB);
    en  = 1'b1;
    rst = 1'b1;
    model_reset();
    clear_stats();
    #12;
    chk("reset_pos", 64'(obs_p), 64'(rst_exp));
    chk("reset_neg", 64'(obs_n), 64'(invert_sync(rst_exp)));
    #5 rst = 1'b0;

    step(1'b1);
    chk("first_sof", 64'({p_sof, p_x, p_y}), 64'({1'b1, CW'(0), CW'(0)}));
    for (int i = 0; i < 40; i++) step(1'b1);

    // Asynchronous reset mid-frame: outputs must drop before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("midreset_pos", 64'(obs_p), 64'(rst_exp));
    chk("midreset_neg", 64'(obs_n), 64'(invert_sync(rst_exp)));
    #2 rst = 1'b0;
    model_reset();
    clear_stats();

    for (int i = 0; i < 2 * FT; i++) step(1'b1);
    chk("active_count", 64'(act_cnt), 64'(2 * HA * VA));
    chk("eol_count", 64'(eol_cnt), 64'(2 * VA));
    chk("eol_position", 64'(eol_bad), 64'd0);
    chk("hsync_window", 64'(hs_bad), 64'd0);
    chk("vsync_window", 64'(vs_bad), 64'd0);
    chk("hsync_count", 64'(hs_cnt), 64'(2 * VT * HS));
    chk("sof_period", 64'(sof_period), 64'(FT));
    chk("frame_cnt_2", 64'(p_fc), 64'd2);

`ifndef VTC_PROG_RUNTIME_CFG_EN
    set_cfg(100, 7, 9, 11, 50, 3, 4, 5);
`endif
    // Pause mid-line: outputs hold and the frame stretches by the pause length.
    clear_stats();
    for (int i = 0; i < HT + 10; i++) step(1'b1);
    for (int i = 0; i < 37; i++) step(1'b0);
    chk("pause_hold_x", 64'(p_x), 64'(HT + 9 - HT));
    run_to_sof("pause");
    chk("pause_period", 64'(sof_period), 64'(FT + 37));
    chk("frame_cnt_3", 64'(p_fc), 64'd3);

`ifdef VTC_PROG_RUNTIME_CFG_EN
    for (int i = 0; i < 50; i++) step(1'b1);
    set_cfg(10, 1, 2, 3, 4, 0, 1, 1);
    run_to_sof("cfg_a_old");
    chk("cfg_old_period", 64'(sof_period), 64'(FT + 50 - 50));
    for (int i = 0; i < 20; i++) step(1'b1);
    set_cfg(6, 0, 0, 2, 3, 1, 0, 1);
    hs_cnt = 0;
    run_to_sof("cfg_a_new");
    chk("cfg_new_period", 64'(sof_period), 64'(16 * 6));
    chk("cfg_new_hs_count", 64'(hs_cnt), 64'(6 * 2));
    hs_cnt = 0;
    run_to_sof("cfg_b");
    chk("cfg_zero_period", 64'(sof_period), 64'(8 * 5));
    chk("cfg_zero_hs_count", 64'(hs_cnt), 64'd0);
    chk("cfg_zero_vsync", 64'(p_vs), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
